// File: rtl/interact_ctrl.sv
// Move sequencer in front of the combinational tile resolver: reads the target
// tile, presents it to the resolver, then commits the player state and map write-back.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for a move; out-of-board targets are answered here
// S_RD     | map read strobe out for the registered target tile
// S_LATCH  | map read data captured into res_tile_id
// S_COMMIT | resolver outputs settled; commit or reject the whole move
module interact_ctrl #(
   parameter int          FLOOR_BITS   = 4,
   parameter logic [3:0]  BOARD_MAX    = 4'd12,
   parameter logic [15:0] FLOOR_MAX    = 16'd9,
   parameter logic [3:0]  START_X      = 4'd6,
   parameter logic [3:0]  START_Y      = 4'd11,
   parameter logic [15:0] START_HEALTH = 16'd10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  move_valid_i,
   input  logic [1:0]            move_dir_i,
   output logic                  move_ready_o,
   output logic                  map_rd_en_o,
   output logic [FLOOR_BITS+7:0] map_rd_addr_o,
   input  logic [15:0]           map_rd_data_i,
   output logic                  map_wr_en_o,
   output logic [FLOOR_BITS+7:0] map_wr_addr_o,
   output logic [15:0]           map_wr_data_o,
   output logic [3:0]            res_pos_x_o,
   output logic [3:0]            res_pos_y_o,
   output logic [15:0]           res_tile_id_o,
   output logic [15:0]           floor_o,
   output logic [3:0]            player_x_o,
   output logic [3:0]            player_y_o,
   output logic [31:0]           key_num_o,
   output logic [15:0]           health_o,
   input  logic [15:0]           res_floor_i,
   input  logic [3:0]            res_goto_x_i,
   input  logic [3:0]            res_goto_y_i,
   input  logic [31:0]           res_key_num_i,
   input  logic [15:0]           res_health_i,
   input  logic [15:0]           res_new_tile_i,
   output logic                  done_o,
   output logic                  blocked_o
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_LATCH, S_COMMIT} state_t;

   state_t                  state_q;
   logic [3:0]              tx_q, ty_q;
   logic [3:0]              tx_d, ty_d;
   logic                    in_range;
   logic [15:0]             floor_q;
   logic [3:0]              player_x_q, player_y_q;
   logic [31:0]             key_num_q;
   logic [15:0]             health_q;
   logic [15:0]             res_tile_id_q;
   logic                    map_rd_en_q;
   logic                    map_wr_en_q;
   logic [FLOOR_BITS+7:0]   map_wr_addr_q;
   logic [15:0]             map_wr_data_q;
   logic                    done_q, blocked_q;

   // Moving up/left from 0 wraps to 4'hF, which the range test also rejects.
   always_comb begin
      tx_d = player_x_q;
      ty_d = player_y_q;
      case (move_dir_i)
         2'd0:    ty_d = player_y_q - 4'd1;
         2'd1:    ty_d = player_y_q + 4'd1;
         2'd2:    tx_d = player_x_q - 4'd1;
         default: tx_d = player_x_q + 4'd1;
      endcase
      in_range = (tx_d <= BOARD_MAX) && (ty_d <= BOARD_MAX);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         tx_q          <= '0;
         ty_q          <= '0;
         floor_q       <= '0;
         player_x_q    <= START_X;
         player_y_q    <= START_Y;
         key_num_q     <= '0;
         health_q      <= START_HEALTH;
         res_tile_id_q <= '0;
         map_rd_en_q   <= 1'b0;
         map_wr_en_q   <= 1'b0;
         map_wr_addr_q <= '0;
         map_wr_data_q <= '0;
         done_q        <= 1'b0;
         blocked_q     <= 1'b0;
      end else begin
         map_rd_en_q <= 1'b0;
         map_wr_en_q <= 1'b0;
         done_q      <= 1'b0;
         blocked_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (move_valid_i) begin
                  if (in_range) begin
                     tx_q        <= tx_d;
                     ty_q        <= ty_d;
                     map_rd_en_q <= 1'b1;
                     state_q     <= S_RD;
                  end else begin
                     done_q    <= 1'b1;
                     blocked_q <= 1'b1;
                  end
               end
            end
            S_RD: state_q <= S_LATCH;
            S_LATCH: begin
               res_tile_id_q <= map_rd_data_i;
               state_q       <= S_COMMIT;
            end
            S_COMMIT: begin
               state_q <= S_IDLE;
               done_q  <= 1'b1;
               // A floor below 0 wraps to 16'hFFFF, so one compare covers both rejects.
               if (res_floor_i > FLOOR_MAX) begin
                  blocked_q <= 1'b1;
               end else begin
                  map_wr_en_q   <= (res_new_tile_i != res_tile_id_q);
                  map_wr_addr_q <= {floor_q[FLOOR_BITS-1:0], ty_q, tx_q};
                  map_wr_data_q <= res_new_tile_i;
                  floor_q       <= res_floor_i;
                  player_x_q    <= res_goto_x_i;
                  player_y_q    <= res_goto_y_i;
                  key_num_q     <= res_key_num_i;
                  health_q      <= res_health_i;
                  blocked_q     <= (res_goto_x_i == player_x_q) && (res_goto_y_i == player_y_q);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign move_ready_o  = (state_q == S_IDLE);
   assign map_rd_en_o   = map_rd_en_q;
   assign map_rd_addr_o = {floor_q[FLOOR_BITS-1:0], ty_q, tx_q};
   assign map_wr_en_o   = map_wr_en_q;
   assign map_wr_addr_o = map_wr_addr_q;
   assign map_wr_data_o = map_wr_data_q;
   assign res_pos_x_o   = tx_q;
   assign res_pos_y_o   = ty_q;
   assign res_tile_id_o = res_tile_id_q;
   assign floor_o       = floor_q;
   assign player_x_o    = player_x_q;
   assign player_y_o    = player_y_q;
   assign key_num_o     = key_num_q;
   assign health_o      = health_q;
   assign done_o        = done_q;
   assign blocked_o     = blocked_q;

endmodule
